sprite_engine: RTL and testbench
================================

Name: sprite_engine

Overview:
- Parametrised sprite renderer for the VGA controller; successor to the fixed 64x64 single-image sprite path.
- Adds animation frames, integer scaling, X/Y mirroring, frame-synchronous shadowing of position/config, and a configurable-latency external ROM interface.
- Sits between the VGA timing generator (pixel coordinates) and the palette decoder/compositor.
- Outputs a colour index plus a visible flag, aligned with a delayed valid strobe.

Parameters:
- SPR_W, 64, sprite width in texels; power of two.
- SPR_H, 64, sprite height in texels; power of two.
- FRAMES, 4, animation frames stored back-to-back in ROM; >=1.
- COLOR_BITS, 3, colour index width.
- ROM_LAT, 1, ROM read latency in cycles; >=1.
- TRANSP_IDX, 0, colour index treated as transparent.
- FRAME_DIV, 8, frame_start pulses per animation step; >=1.
- ADDR_W, clog2(FRAMES*SPR_W*SPR_H), ROM address width; derived, not overridden.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- pos_x, pos_y  in  10 each  top-left screen coordinate (live; shadowed)
- scale  in  2  magnification = 1<<scale (1,2,4,8) (live; shadowed)
- mirror_x, mirror_y  in  1 each  flip horizontally/vertically (live; shadowed)
- anim_en  in  1  enable frame advance (live; shadowed)
- spr_en  in  1  sprite enable (live; shadowed)
- pixel_x, pixel_y  in  10 each  current beam coordinate
- pixel_valid  in  1  coordinate is in the active area
- rom_addr  out  ADDR_W  texel address, registered
- rom_data  in  COLOR_BITS  texel index, valid ROM_LAT cycles after rom_addr
- out_idx  out  COLOR_BITS  colour index
- out_visible  out  1  pixel belongs to the sprite and is opaque
- out_valid  out  1  pixel_valid delayed to align with out_idx
- cur_frame  out  clog2(FRAMES) (min 1)  current animation frame

Behaviour:
- Async reset, all cleared to 0: shadow regs, frame counter, div counter, pipeline, rom_addr, out_idx, out_visible, out_valid, cur_frame. spr_en shadow=0 keeps out_visible=0 until the first frame_start.
- Shadowing:
  - On a cycle with frame_start=1, latch pos_x/pos_y/scale/mirror_x/mirror_y/anim_en/spr_en into shadow regs.
  - Only shadow values drive address generation, so a mid-frame change of a live input has no effect until the next frame_start.
  - A pixel presented in the same cycle as frame_start uses the old shadow.
- Animation:
  - div_cnt counts frame_start pulses when shadow anim_en=1 (new value, i.e. the value latched that same edge).
  - At div_cnt==FRAME_DIV-1: div_cnt->0 and cur_frame increments, wrapping FRAMES-1->0.
  - anim_en=0 holds both counters.
  - FRAMES=1: cur_frame is constantly 0.
- Stage A (registered into rom_addr):
  - dx = {1'b0,pixel_x} - {1'b0,pos_x}, 11-bit signed; dy likewise.
  - inside = pixel_valid & spr_en & dx>=0 & dx<(SPR_W<<scale) & dy>=0 & dy<(SPR_H<<scale).
  - col = dx>>scale; row = dy>>scale.
  - If mirror_x, col = SPR_W-1-col; if mirror_y, row = SPR_H-1-row.
  - rom_addr = cur_frame*SPR_W*SPR_H + row*SPR_W + col, built by concatenation.
  - When !inside, rom_addr is don't-care; the implementation holds the previous value.
  - inside and pixel_valid enter a ROM_LAT-deep delay line.
- Stage B (output register, ROM_LAT cycles after stage A):
  - out_idx = rom_data.
  - out_visible = inside_d & (rom_data != TRANSP_IDX).
  - out_valid = pixel_valid_d.
  - When !inside_d, out_idx=0.
- Latency: pixel input to outputs = ROM_LAT+2 cycles, fixed and independent of visibility.
- Clipping:
  - A sprite partly beyond column 639 or row 479 is clipped naturally; no wrap to the left/top.
  - pos_x=1023 never wraps to dx>=0 for small pixel_x.
- cur_frame changes only on frame_start, so there is no tearing within a frame.

Test Plan:
- Reset then frame_start with pos=(100,50), scale=0, spr_en=1; ROM texel(0,0)=5 -> for pixel (100,50), rom_addr=0 one cycle later; out_idx=5, out_visible=1 at ROM_LAT+2 cycles. Pixel (99,50) -> out_visible=0, out_idx=0.
- scale=2, pos=(0,0) -> pixels x=0..3 all read col 0; x=255 reads col 63; x=256 -> out_visible=0.
- mirror_x=1, scale=0, pos=(0,0) -> pixel (0,0) gives rom_addr=63; mirror_y=1 additionally -> rom_addr=4095.
- anim_en=1, FRAME_DIV=8, FRAMES=4 -> cur_frame advances on the 8th, 16th, 24th, 32nd frame_start, reading 1,2,3,0. Frame 2, texel(0,0) -> rom_addr=8192.
- Change pos_x mid-frame -> no output change until after the next frame_start. Texel==TRANSP_IDX inside the sprite -> out_visible=0, out_valid=1.
- Assert rst_n low mid-line -> all outputs 0 immediately (async); after release, out_visible stays 0 until frame_start.

Source files
------------

// File: rtl/sprite_engine.sv
// Sprite renderer: frame-synchronous shadowed config, animated frames, integer scaling,
// mirroring, and a configurable-latency ROM pipeline producing colour index + visibility.
module sprite_engine #(
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 64,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned COLOR_BITS = 3,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned FRAME_DIV  = 8,
  localparam int unsigned ADDR_W    = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int unsigned FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic [1:0]            scale,
  input  logic                  mirror_x,
  input  logic                  mirror_y,
  input  logic                  anim_en,
  input  logic                  spr_en,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  pixel_valid,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [COLOR_BITS-1:0] rom_data,
  output logic [COLOR_BITS-1:0] out_idx,
  output logic                  out_visible,
  output logic                  out_valid,
  output logic [FRAME_W-1:0]    cur_frame
);

  localparam int unsigned COL_W = $clog2(SPR_W);
  localparam int unsigned ROW_W = $clog2(SPR_H);
  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned LIM_W = 16;

  logic [9:0]            r_pos_x, r_pos_y;
  logic [1:0]            r_scale;
  logic                  r_mirror_x, r_mirror_y, r_anim_en, r_spr_en;
  logic [DIV_W-1:0]      r_div;
  logic [FRAME_W-1:0]    r_frame;
  logic [ADDR_W-1:0]     r_rom_addr;
  logic [ROM_LAT:0]      r_ins_d, r_vld_d;
  logic [COLOR_BITS-1:0] r_out_idx;
  logic                  r_out_visible, r_out_valid;

  logic [10:0]           w_dx, w_dy;
  logic [LIM_W-1:0]      w_lim_x, w_lim_y;
  logic [COL_W-1:0]      w_col_raw, w_col;
  logic [ROW_W-1:0]      w_row_raw, w_row;
  logic                  w_inside;

  // Shadow registers and animation counters advance only on frame_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_x    <= '0;
      r_pos_y    <= '0;
      r_scale    <= '0;
      r_mirror_x <= 1'b0;
      r_mirror_y <= 1'b0;
      r_anim_en  <= 1'b0;
      r_spr_en   <= 1'b0;
      r_div      <= '0;
      r_frame    <= '0;
    end else if (frame_start) begin
      r_pos_x    <= pos_x;
      r_pos_y    <= pos_y;
      r_scale    <= scale;
      r_mirror_x <= mirror_x;
      r_mirror_y <= mirror_y;
      r_anim_en  <= anim_en;
      r_spr_en   <= spr_en;
      if (anim_en) begin
        if (r_div == DIV_W'(FRAME_DIV - 1)) begin
          r_div   <= '0;
          r_frame <= (r_frame == FRAME_W'(FRAMES - 1)) ? '0 : r_frame + FRAME_W'(1);
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end
  end

  // Bit 10 of the 11-bit difference is the sign: beam left of / above the sprite
  assign w_dx      = {1'b0, pixel_x} - {1'b0, r_pos_x};
  assign w_dy      = {1'b0, pixel_y} - {1'b0, r_pos_y};
  assign w_lim_x   = LIM_W'(SPR_W) << r_scale;
  assign w_lim_y   = LIM_W'(SPR_H) << r_scale;
  assign w_inside  = pixel_valid & r_spr_en
                   & ~w_dx[10] & (LIM_W'(w_dx[9:0]) < w_lim_x)
                   & ~w_dy[10] & (LIM_W'(w_dy[9:0]) < w_lim_y);
  assign w_col_raw = COL_W'(w_dx[9:0] >> r_scale);
  assign w_row_raw = ROW_W'(w_dy[9:0] >> r_scale);
  assign w_col     = r_mirror_x ? COL_W'(SPR_W - 1) - w_col_raw : w_col_raw;
  assign w_row     = r_mirror_y ? ROW_W'(SPR_H - 1) - w_row_raw : w_row_raw;

  // Stage A: texel address plus delay line matching the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_ins_d    <= '0;
      r_vld_d    <= '0;
    end else begin
      if (w_inside) begin
        r_rom_addr <= ADDR_W'({r_frame, w_row, w_col});
      end
      r_ins_d <= {r_ins_d[ROM_LAT-1:0], w_inside};
      r_vld_d <= {r_vld_d[ROM_LAT-1:0], pixel_valid};
    end
  end

  // Stage B: output register aligned with returning ROM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_idx     <= '0;
      r_out_visible <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_out_idx     <= r_ins_d[ROM_LAT] ? rom_data : '0;
      r_out_visible <= r_ins_d[ROM_LAT] & (rom_data != COLOR_BITS'(TRANSP_IDX));
      r_out_valid   <= r_vld_d[ROM_LAT];
    end
  end

  assign rom_addr    = r_rom_addr;
  assign out_idx     = r_out_idx;
  assign out_visible = r_out_visible;
  assign out_valid   = r_out_valid;
  assign cur_frame   = r_frame;

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine against an arithmetic model of sprite placement.
module tb_sprite_engine;

  localparam int unsigned LAT = 1;
  localparam int unsigned AW  = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [9:0]    pos_x = '0, pos_y = '0;
  logic [1:0]    scale = '0;
  logic          mirror_x = 1'b0, mirror_y = 1'b0, anim_en = 1'b0, spr_en = 1'b0;
  logic [9:0]    pixel_x = '0, pixel_y = '0;
  logic          pixel_valid = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [2:0]    rom_data = '0;
  logic [2:0]    out_idx;
  logic          out_visible, out_valid;
  logic [1:0]    cur_frame;

  logic [2:0]    rom_mem [0:16383];
  int            n_total = 0;
  int            n_bad = 0;

  int m_px, m_py, m_sc, m_mx, m_my, m_an, m_en, m_frame, m_div;

  sprite_engine dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .scale(scale),
    .mirror_x(mirror_x), .mirror_y(mirror_y), .anim_en(anim_en), .spr_en(spr_en),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_idx(out_idx), .out_visible(out_visible), .out_valid(out_valid),
    .cur_frame(cur_frame)
  );

  always #5 clk = ~clk;

  // One-cycle-latency texel ROM
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  function automatic void model_reset();
    m_px = 0; m_py = 0; m_sc = 0; m_mx = 0; m_my = 0; m_an = 0; m_en = 0;
    m_frame = 0; m_div = 0;
  endfunction

  // Expected placement from plain arithmetic on the shadowed configuration
  function automatic void model(input int px, input int py, output bit ins, output int addr,
                                output logic [2:0] idx, output bit vis);
    int m, sx, sy, col, row;
    m   = 1 << m_sc;
    sx  = px - m_px;
    sy  = py - m_py;
    ins = (m_en != 0) && sx >= 0 && sx < 64 * m && sy >= 0 && sy < 64 * m;
    col = ins ? sx / m : 0;
    row = ins ? sy / m : 0;
    if (m_mx != 0) col = 63 - col;
    if (m_my != 0) row = 63 - row;
    addr = m_frame * 4096 + row * 64 + col;
    idx  = ins ? rom_mem[addr] : 3'd0;
    vis  = ins && idx != 3'd0;
  endfunction

  task automatic set_cfg(input int px, input int py, input int sc, input int mx, input int my,
                         input int an, input int en);
    pos_x = 10'(px); pos_y = 10'(py); scale = 2'(sc);
    mirror_x = 1'(mx); mirror_y = 1'(my); anim_en = 1'(an); spr_en = 1'(en);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    m_px = int'(pos_x); m_py = int'(pos_y); m_sc = int'(scale);
    m_mx = int'(mirror_x); m_my = int'(mirror_y); m_an = int'(anim_en); m_en = int'(spr_en);
    if (m_an != 0) begin
      m_div = m_div + 1;
      if (m_div == 8) begin
        m_div = 0;
        m_frame = (m_frame + 1) % 4;
      end
    end
  endtask

  task automatic send(input int x, input int y);
    pixel_x = 10'(x); pixel_y = 10'(y); pixel_valid = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ins, vs; int a; logic [2:0] ix;
    n_total++; if (rom_addr !== '0) begin n_bad++; $display("FAIL reset_addr got %0d exp 0", rom_addr); end
    n_total++; if (out_idx !== '0) begin n_bad++; $display("FAIL reset_idx got %0d exp 0", out_idx); end
    n_total++; if (out_visible !== 1'b0) begin n_bad++; $display("FAIL reset_vis got %b exp 0", out_visible); end
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_total++; if (cur_frame !== '0) begin n_bad++; $display("FAIL reset_frame got %0d exp 0", cur_frame); end
    set_cfg(0, 0, 0, 0, 0, 0, 1);
    model(3, 3, ins, a, ix, vs);
    send(3, 3);
    repeat (LAT + 1) @(negedge clk);
    n_total++;
    if ({out_valid, out_visible, out_idx} !== {1'b1, vs, ix}) begin
      n_bad++; $display("FAIL reset_noshadow got v=%b vis=%b idx=%0d exp 1/%b/%0d", out_valid, out_visible, out_idx, vs, ix);
    end
  endtask

  task automatic test_basic();
    int xs[5]; int ys[5]; bit ins, vs; int a; logic [2:0] ix;
    xs = '{100, 99, 163, 164, 130}; ys = '{50, 50, 113, 50, 49};
    rom_mem[0] = 3'd5;
    set_cfg(100, 50, 0, 0, 0, 0, 1); pulse_fs();
    foreach (xs[i]) begin
      model(xs[i], ys[i], ins, a, ix, vs);
      send(xs[i], ys[i]);
      if (ins) begin
        n_total++; if (rom_addr !== AW'(a)) begin n_bad++; $display("FAIL basic_addr[%0d] got %0d exp %0d", i, rom_addr, a); end
      end
      repeat (LAT + 1) @(negedge clk);
      n_total++;
      if ({out_valid, out_visible, out_idx} !== {1'b1, vs, ix}) begin
        n_bad++; $display("FAIL basic_out[%0d] got v=%b vis=%b idx=%0d exp 1/%b/%0d", i, out_valid, out_visible, out_idx, vs, ix);
      end
    end
  endtask

  task automatic test_scale();
    int xs[7]; bit ins, vs; int a; logic [2:0] ix;
    xs = '{0, 1, 2, 3, 4, 255, 256};
    set_cfg(0, 0, 2, 0, 0, 0, 1); pulse_fs();
    foreach (xs[i]) begin
      model(xs[i], 9, ins, a, ix, vs);
      send(xs[i], 9);
      if (ins) begin
        n_total++; if (rom_addr !== AW'(a)) begin n_bad++; $display("FAIL scale_addr[%0d] got %0d exp %0d", i, rom_addr, a); end
      end
      repeat (LAT + 1) @(negedge clk);
      n_total++;
      if ({out_valid, out_visible, out_idx} !== {1'b1, vs, ix}) begin
        n_bad++; $display("FAIL scale_out[%0d] got v=%b vis=%b idx=%0d exp 1/%b/%0d", i, out_valid, out_visible, out_idx, vs, ix);
      end
    end
  endtask

  task automatic test_mirror();
    bit ins, vs; int a; logic [2:0] ix;
    for (int k = 0; k < 2; k++) begin
      set_cfg(0, 0, 0, 1, k, 0, 1); pulse_fs();
      model(0, 0, ins, a, ix, vs);
      send(0, 0);
      n_total++; if (rom_addr !== AW'(a)) begin n_bad++; $display("FAIL mirror_addr[%0d] got %0d exp %0d", k, rom_addr, a); end
      repeat (LAT + 1) @(negedge clk);
      n_total++;
      if ({out_visible, out_idx} !== {vs, ix}) begin
        n_bad++; $display("FAIL mirror_out[%0d] got vis=%b idx=%0d exp %b/%0d", k, out_visible, out_idx, vs, ix);
      end
    end
  endtask

  task automatic test_shadow();
    bit ins, vs; int a; logic [2:0] ix;
    set_cfg(200, 100, 0, 0, 0, 0, 1); pulse_fs();
    pos_x = 10'd300;
    for (int k = 0; k < 2; k++) begin
      model(200, 100, ins, a, ix, vs);
      send(200, 100);
      if (ins) begin
        n_total++; if (rom_addr !== AW'(a)) begin n_bad++; $display("FAIL shadow_addr[%0d] got %0d exp %0d", k, rom_addr, a); end
      end
      repeat (LAT + 1) @(negedge clk);
      n_total++;
      if ({out_valid, out_visible, out_idx} !== {1'b1, vs, ix}) begin
        n_bad++; $display("FAIL shadow_out[%0d] got v=%b vis=%b idx=%0d exp 1/%b/%0d", k, out_valid, out_visible, out_idx, vs, ix);
      end
      if (k == 0) pulse_fs();
    end
    // Pixel in the frame_start cycle still sees the old shadow
    set_cfg(500, 400, 0, 0, 0, 0, 1);
    model(320, 110, ins, a, ix, vs);
    pixel_x = 10'd320; pixel_y = 10'd110; pixel_valid = 1'b1;
    pulse_fs();
    pixel_valid = 1'b0;
    n_total++; if (!ins || rom_addr !== AW'(a)) begin n_bad++; $display("FAIL fs_same_cycle_addr got %0d exp %0d", rom_addr, a); end
    repeat (LAT + 1) @(negedge clk);
    n_total++;
    if ({out_visible, out_idx} !== {vs, ix}) begin
      n_bad++; $display("FAIL fs_same_cycle_out got vis=%b idx=%0d exp %b/%0d", out_visible, out_idx, vs, ix);
    end
    // Transparent texel inside the sprite
    rom_mem[m_frame * 4096 + 2 * 64 + 3] = 3'd0;
    model(503, 402, ins, a, ix, vs);
    send(503, 402);
    repeat (LAT + 1) @(negedge clk);
    n_total++;
    if ({out_valid, out_visible, out_idx} !== 5'b1_0_000 || vs) begin
      n_bad++; $display("FAIL transp got v=%b vis=%b idx=%0d exp 1/0/0", out_valid, out_visible, out_idx);
    end
  endtask

  task automatic test_clip();
    int xs[5]; int ys[5]; bit ins, vs; int a; logic [2:0] ix;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin set_cfg(1023, 0, 3, 0, 0, 0, 1); xs = '{0, 5, 10, 1023, 200}; ys = '{0, 1, 2, 3, 4}; end
      else begin set_cfg(600, 450, 1, 0, 0, 0, 1); xs = '{639, 5, 600, 1000, 700}; ys = '{479, 5, 450, 460, 2}; end
      pulse_fs();
      foreach (xs[i]) begin
        model(xs[i], ys[i], ins, a, ix, vs);
        send(xs[i], ys[i]);
        if (ins) begin
          n_total++; if (rom_addr !== AW'(a)) begin n_bad++; $display("FAIL clip_addr[%0d] got %0d exp %0d", i, rom_addr, a); end
        end
        repeat (LAT + 1) @(negedge clk);
        n_total++;
        if ({out_visible, out_idx} !== {vs, ix}) begin
          n_bad++; $display("FAIL clip_out[%0d,%0d] got vis=%b idx=%0d exp %b/%0d", k, i, out_visible, out_idx, vs, ix);
        end
      end
    end
  endtask

  task automatic test_anim();
    bit ins, vs; int a; logic [2:0] ix;
    set_cfg(0, 0, 0, 0, 0, 1, 1);
    for (int p = 1; p <= 34; p++) begin
      if (p > 32) anim_en = 1'b0;
      pulse_fs();
      n_total++;
      if (cur_frame !== 2'(m_frame)) begin n_bad++; $display("FAIL anim_frame[%0d] got %0d exp %0d", p, cur_frame, m_frame); end
      if (p == 16) begin
        model(0, 0, ins, a, ix, vs);
        send(0, 0);
        n_total++; if (rom_addr !== AW'(a)) begin n_bad++; $display("FAIL anim_addr got %0d exp %0d", rom_addr, a); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit e_ins[64]; bit e_vis[64]; bit e_pv[64]; int e_addr[64]; logic [2:0] e_idx[64];
    bit ins, vs; int a, x, y, k; logic [2:0] ix;
    for (int c = 0; c < 4; c++) begin
      set_cfg(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3) != 0));
      pulse_fs();
      for (int i = 0; i < 64 + LAT + 2; i++) begin
        if (i >= 1 && i <= 64 && e_ins[i-1]) begin
          n_total++;
          if (rom_addr !== AW'(e_addr[i-1])) begin n_bad++; $display("FAIL b2b_addr[%0d,%0d] got %0d exp %0d", c, i-1, rom_addr, e_addr[i-1]); end
        end
        if (i >= LAT + 2) begin
          k = i - LAT - 2;
          n_total++;
          if ({out_valid, out_visible, out_idx} !== {e_pv[k], e_vis[k], e_idx[k]}) begin
            n_bad++; $display("FAIL b2b_out[%0d,%0d] got v=%b vis=%b idx=%0d exp %b/%b/%0d", c, k,
                              out_valid, out_visible, out_idx, e_pv[k], e_vis[k], e_idx[k]);
          end
        end
        if (i < 64) begin
          x = (m_px - 8 + int'($urandom_range(0, (64 << m_sc) + 16))) & 1023;
          y = (m_py - 8 + int'($urandom_range(0, (64 << m_sc) + 16))) & 1023;
          e_pv[i] = ($urandom_range(0, 7) != 0);
          model(x, y, ins, a, ix, vs);
          e_ins[i] = ins && e_pv[i]; e_addr[i] = a;
          e_idx[i] = e_ins[i] ? ix : 3'd0; e_vis[i] = vs && e_pv[i];
          pixel_x = 10'(x); pixel_y = 10'(y); pixel_valid = e_pv[i];
        end else begin
          pixel_valid = 1'b0;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ins, vs; int a; logic [2:0] ix;
    set_cfg(0, 0, 0, 0, 0, 0, 1); pulse_fs();
    pixel_x = 10'd5; pixel_y = 10'd5; pixel_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (rom_addr !== '0) begin n_bad++; $display("FAIL arst_addr got %0d exp 0", rom_addr); end
    n_total++; if (out_idx !== '0) begin n_bad++; $display("FAIL arst_idx got %0d exp 0", out_idx); end
    n_total++; if (out_visible !== 1'b0) begin n_bad++; $display("FAIL arst_vis got %b exp 0", out_visible); end
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    n_total++; if (cur_frame !== '0) begin n_bad++; $display("FAIL arst_frame got %0d exp 0", cur_frame); end
    @(negedge clk);
    pixel_valid = 1'b0; rst_n = 1'b1;
    model_reset();
    model(5, 5, ins, a, ix, vs);
    send(5, 5);
    repeat (LAT + 1) @(negedge clk);
    n_total++;
    if ({out_valid, out_visible, out_idx} !== {1'b1, vs, ix}) begin
      n_bad++; $display("FAIL arst_after got v=%b vis=%b idx=%0d exp 1/%b/%0d", out_valid, out_visible, out_idx, vs, ix);
    end
  endtask

  initial begin
    foreach (rom_mem[i]) rom_mem[i] = 3'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_scale();
    test_mirror();
    test_shadow();
    test_clip();
    test_anim();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
